demux_1x2_buffered: RTL and testbench

- Inverse of the 32-bit 2-to-1 datapath select: one 32-bit producer stream is steered to one of two consumer lanes (A, B) by a select bit. sel=0 routes to A and sel=1 routes to B, matching the mux convention ctrl=0→A.
- Each lane has a small registered FIFO with valid/ready handshakes, so a stalled consumer does not block the other lane's backlog.
- Sits between the execute-stage result bus and two writeback consumers.

---
 rtl/demux_1x2_buffered_pkg.sv | 21 ++
 rtl/demux_1x2_buffered_sync_fifo.sv | 86 ++++++++
 rtl/demux_1x2_buffered.sv | 73 +++++++
 tb/tb_demux_1x2_buffered.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/demux_1x2_buffered_pkg.sv
// Shared constants and helpers for the 1-to-2 buffered demux and its lane FIFOs.
package demux_1x2_buffered_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    typedef enum logic [1:0] {
        LANE_EMPTY,
        LANE_PARTIAL,
        LANE_FULL
    } lane_state_e;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int cnt_w_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux_1x2_buffered_sync_fifo.sv
// Registered per-lane FIFO; head word always comes from storage, never bypassed from the write port.
//   state        | meaning
//   LANE_EMPTY   | count == 0, head invalid
//   LANE_PARTIAL | 0 < count < DEPTH
//   LANE_FULL    | count == DEPTH, pushes refused
module sync_fifo
    import demux_1x2_buffered_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = cnt_w_f(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    lane_state_e       state;
    logic              do_push, do_pop;

    always_comb begin
        state = LANE_PARTIAL;
        if (count_q == '0) begin
            state = LANE_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            state = LANE_FULL;
        end
    end

    assign full     = (state == LANE_FULL);
    assign empty    = (state == LANE_EMPTY);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux_1x2_buffered.sv
// Steers one producer stream into lane A (sel=0) or lane B (sel=1), each behind its own FIFO.
module demux_1x2_buffered
    import demux_1x2_buffered_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = cnt_w_f(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [DATA_W-1:0] b_data,
    output logic [CNT_W-1:0]  a_count,
    output logic [CNT_W-1:0]  b_count
);

    logic a_full, b_full;
    logic a_empty, b_empty;
    logic a_push, b_push;
    logic sel_full;

    // Ready depends only on the selected lane's registered fullness; rst_n holds it low in reset.
    always_comb begin
        sel_full = (in_sel == LANE_B) ? b_full : a_full;
        in_ready = rst_n & ~sel_full;
        a_push   = in_valid & in_ready & (in_sel == LANE_A);
        b_push   = in_valid & in_ready & (in_sel == LANE_B);
    end

    assign a_valid = ~a_empty;
    assign b_valid = ~b_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_ready),
        .pop_data  (a_data),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_ready),
        .pop_data  (b_data),
        .full      (b_full),
        .empty     (b_empty),
        .count     (b_count)
    );

endmodule

// File: tb/tb_demux_1x2_buffered.sv
// Scoreboard bench: driver queues expected words per lane, negedge monitor checks heads, pops and occupancy.
module tb_demux_1x2_buffered;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_sel, a_ready, b_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, a_valid, b_valid;
    logic [DATA_W-1:0] a_data, b_data;
    logic [CNT_W-1:0]  a_count, b_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int   occ_a = 0, occ_b = 0;
    bit   pend_push_a, pend_push_b, pend_pop_a, pend_pop_b;
    bit   exp_ready = 1'b1;

    demux_1x2_buffered #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: inputs are stable here, so a visible handshake is the pop at the next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            chk("a_count", {29'd0, a_count}, 32'(occ_a));
            chk("b_count", {29'd0, b_count}, 32'(occ_b));
            chk("a_valid", {31'd0, a_valid}, {31'd0, occ_a != 0});
            chk("b_valid", {31'd0, b_valid}, {31'd0, occ_b != 0});
            if (a_valid) begin
                if (exp_a.size() == 0) chk("a_unexpected", a_data, 32'hxxxx_xxxx);
                else begin
                    chk("a_data", a_data, exp_a[0]);
                    if (a_ready) void'(exp_a.pop_front());
                end
            end
            if (b_valid) begin
                if (exp_b.size() == 0) chk("b_unexpected", b_data, 32'hxxxx_xxxx);
                else begin
                    chk("b_data", b_data, exp_b[0]);
                    if (b_ready) void'(exp_b.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus: account for the edge just passed, then present new inputs.
    task automatic drive(input bit v, input bit s, input logic [31:0] d, input bit ar, input bit br);
        @(posedge clk);
        #1;
        occ_a += int'(pend_push_a) - int'(pend_pop_a);
        occ_b += int'(pend_push_b) - int'(pend_pop_b);
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
        exp_ready   = ((s ? occ_b : occ_a) < DEPTH);
        pend_push_a = v && exp_ready && !s;
        pend_push_b = v && exp_ready && s;
        pend_pop_a  = ar && (occ_a > 0);
        pend_pop_b  = br && (occ_b > 0);
        if (pend_push_a) exp_a.push_back(d);
        if (pend_push_b) exp_b.push_back(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_valid"}, {31'd0, a_valid}, 32'd0);
        chk({tag, "_b_valid"}, {31'd0, b_valid}, 32'd0);
        chk({tag, "_a_data"}, a_data, 32'd0);
        chk({tag, "_b_data"}, b_data, 32'd0);
        chk({tag, "_a_count"}, {29'd0, a_count}, 32'd0);
        chk({tag, "_b_count"}, {29'd0, b_count}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic clear_model();
        exp_a.delete(); exp_b.delete();
        occ_a = 0; occ_b = 0;
        pend_push_a = 0; pend_push_b = 0; pend_pop_a = 0; pend_pop_b = 0;
        in_valid = 0; in_sel = 0; in_data = '0; a_ready = 0; b_ready = 0;
        exp_ready = 1'b1;
    endtask

    initial begin
        clear_model();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rst_init_release_ready", {31'd0, in_ready}, 32'd1);

        // Routing and one-cycle latency
        drive(1, 0, 32'hDEAD_BEEF, 0, 0);
        drive(1, 1, 32'h1234_5678, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 1, 1);
        drive(0, 0, 32'h0, 0, 0);

        // Fill lane A, probe refusal, then show lane B still accepts
        for (int i = 1; i <= 4; i++) drive(1, 0, 32'(i), 0, 0);
        drive(1, 0, 32'h99, 0, 0);
        drive(1, 1, 32'hAA, 0, 0);
        // Full lane popping in the same cycle still refuses; next push lands
        drive(1, 0, 32'h5, 1, 0);
        drive(1, 0, 32'h5, 0, 0);
        repeat (6) drive(0, 0, 32'h0, 1, 1);

        // Continuous stream through A with pointer wrap
        for (int i = 0; i < 10; i++) drive(1, 0, 32'h10 + 32'(i), 1, 0);
        repeat (2) drive(0, 0, 32'h0, 1, 0);

        // B stalled full while A streams, then B drains
        for (int i = 0; i < 4; i++) drive(1, 1, 32'hB0 + 32'(i), 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 32'h20 + 32'(i), 1, 0);
        drive(0, 0, 32'h0, 1, 0);
        repeat (6) drive(0, 1, 32'h0, 1, 1);

        // Asynchronous reset mid-cycle with two words in each lane
        drive(1, 0, 32'hA1, 0, 0);
        drive(1, 0, 32'hA2, 0, 0);
        drive(1, 1, 32'hB1, 0, 0);
        drive(1, 1, 32'hB2, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_mid_release_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_release_a_count", {29'd0, a_count}, 32'd0);
        chk("rst_mid_release_b_count", {29'd0, b_count}, 32'd0);

        // Randomized traffic with readies biased low to reach full often
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        repeat (12) drive(0, 0, 32'h0, 1, 1);
        @(negedge clk);
        chk("final_a_drained", 32'(exp_a.size()), 32'd0);
        chk("final_b_drained", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
